// File: rtl/car_motion_ctrl.sv
// Car X position from raw left/right buttons, updated only on frame_tick so it never moves mid-frame.
// Latency: button edge -> moving is 2 sync + DEB_CYCLES + 1 clk; car_x moves on the following frame_tick.
// Backpressure: none; the renderer samples car_x directly.
module car_motion_ctrl #(
    parameter int DEB_CYCLES   = 250000,
    parameter int ACCEL_FRAMES = 8,
    parameter int MAX_SPEED    = 4,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 600,
    parameter int X_INIT       = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       frame_tick,
    output logic [9:0] car_x,
    output logic [2:0] speed,
    output logic       moving,
    output logic       dir_left
);

    localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int AW = (ACCEL_FRAMES > 2) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [AW-1:0] ACC_LAST = AW'(ACCEL_FRAMES - 1);
    localparam logic [2:0]    SPD_MAX  = 3'(MAX_SPEED);
    localparam logic [10:0]   XMIN11   = 11'(X_MIN);
    localparam logic [10:0]   XMAX11   = 11'(X_MAX);
    localparam logic [9:0]    XMIN10   = 10'(X_MIN);
    localparam logic [9:0]    XMAX10   = 10'(X_MAX);
    localparam logic [9:0]    XINIT10  = 10'(X_INIT);

    typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

    logic [1:0]    btn_raw;
    logic [1:0]    meta;
    logic [1:0]    sync;
    logic [1:0]    stable;
    logic [DW-1:0] deb_cnt [2];

    state_t        state;
    state_t        nxt_state;
    logic [AW-1:0] accel_cnt;
    logic [10:0]   sum_r;
    logic [10:0]   lim_l;
    logic [9:0]    x_next;

    assign btn_raw = {btn_right, btn_left};

    // Index 0 is left, index 1 is right; a change is accepted only after DEB_CYCLES stable cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta       <= '0;
            sync       <= '0;
            stable     <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            meta <= btn_raw;
            sync <= meta;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    stable[i]  <= sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        nxt_state = IDLE;
        if (stable[0] && !stable[1]) begin
            nxt_state = MOVE_L;
        end else if (stable[1] && !stable[0]) begin
            nxt_state = MOVE_R;
        end
    end

    // 11-bit arithmetic keeps both edge clamps free of wrap-around.
    always_comb begin
        sum_r  = {1'b0, car_x} + {8'b0, speed};
        lim_l  = XMIN11 + {8'b0, speed};
        x_next = car_x;
        case (state)
            MOVE_L:  x_next = ({1'b0, car_x} < lim_l) ? XMIN10 : car_x - {7'b0, speed};
            MOVE_R:  x_next = (sum_r > XMAX11) ? XMAX10 : sum_r[9:0];
            default: x_next = car_x;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            moving    <= 1'b0;
            dir_left  <= 1'b0;
            speed     <= 3'd1;
            accel_cnt <= '0;
            car_x     <= XINIT10;
        end else begin
            if (nxt_state != state) begin
                state     <= nxt_state;
                moving    <= (nxt_state != IDLE);
                dir_left  <= (nxt_state == MOVE_L);
                speed     <= 3'd1;
                accel_cnt <= '0;
            end else if (frame_tick && state != IDLE) begin
                if (accel_cnt == ACC_LAST) begin
                    accel_cnt <= '0;
                    if (speed < SPD_MAX) begin
                        speed <= speed + 3'd1;
                    end
                end else begin
                    accel_cnt <= accel_cnt + 1'b1;
                end
            end
            // Position uses the state and speed held before this edge.
            if (frame_tick) begin
                car_x <= x_next;
            end
        end
    end

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Directed bench for car_motion_ctrl with short debounce; extra instances cover the track edges.
module tb_car_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] car_x;
    logic [2:0] speed;
    logic       moving;
    logic       dir_left;

    logic       hi_right = 1'b0;
    logic [9:0] hi_x;
    logic [2:0] hi_speed;
    logic       hi_moving;
    logic       hi_dir;

    logic       lo_left = 1'b0;
    logic [9:0] lo_x;
    logic [2:0] lo_speed;
    logic       lo_moving;
    logic       lo_dir;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    car_motion_ctrl #(.DEB_CYCLES(4), .ACCEL_FRAMES(2), .MAX_SPEED(4),
                      .X_MIN(0), .X_MAX(600), .X_INIT(100)) dut (
        .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
        .frame_tick(frame_tick), .car_x(car_x), .speed(speed), .moving(moving),
        .dir_left(dir_left));

    car_motion_ctrl #(.DEB_CYCLES(4), .ACCEL_FRAMES(2), .MAX_SPEED(4),
                      .X_MIN(0), .X_MAX(600), .X_INIT(598)) dut_hi (
        .clk(clk), .reset(reset), .btn_left(1'b0), .btn_right(hi_right),
        .frame_tick(frame_tick), .car_x(hi_x), .speed(hi_speed), .moving(hi_moving),
        .dir_left(hi_dir));

    car_motion_ctrl #(.DEB_CYCLES(4), .ACCEL_FRAMES(2), .MAX_SPEED(4),
                      .X_MIN(0), .X_MAX(600), .X_INIT(1)) dut_lo (
        .clk(clk), .reset(reset), .btn_left(lo_left), .btn_right(1'b0),
        .frame_tick(frame_tick), .car_x(lo_x), .speed(lo_speed), .moving(lo_moving),
        .dir_left(lo_dir));

    task automatic do_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        hi_right  = 1'b0;
        lo_left   = 1'b0;
        reset     = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (car_x !== 10'd100 || speed !== 3'd1 || moving !== 1'b0 || dir_left !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: car_x=%0d speed=%0d moving=%0d dir_left=%0d, expected 100 1 0 0",
                     car_x, speed, moving, dir_left);
        end
        for (int i = 0; i < 10; i++) begin
            do_tick();
            checks++;
            if (car_x !== 10'd100 || speed !== 3'd1 || moving !== 1'b0) begin
                errors++;
                $display("FAIL idle_tick%0d: car_x=%0d speed=%0d moving=%0d, expected 100 1 0",
                         i, car_x, speed, moving);
            end
        end
    endtask

    task automatic test_debounce_latency();
        @(negedge clk);
        btn_left = 1'b1;
        repeat (3) @(negedge clk);
        btn_left = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (moving !== 1'b0) begin
                errors++;
                $display("FAIL short_pulse c%0d: moving=%0d expected 0", i, moving);
            end
        end
        btn_left = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if (moving !== 1'b0) begin
                errors++;
                $display("FAIL latency_early edge%0d: moving=%0d expected 0", i, moving);
            end
        end
        @(negedge clk);
        checks++;
        if (moving !== 1'b1 || dir_left !== 1'b1) begin
            errors++;
            $display("FAIL latency_edge7: moving=%0d dir_left=%0d expected 1 1", moving, dir_left);
        end
        do_tick();
        checks++;
        if (car_x !== 10'd99) begin
            errors++;
            $display("FAIL first_left_tick: car_x=%0d expected 99", car_x);
        end
        btn_left = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (moving !== 1'b0 || car_x !== 10'd99) begin
            errors++;
            $display("FAIL release_left: moving=%0d car_x=%0d expected 0 99", moving, car_x);
        end
    endtask

    task automatic test_accel();
        logic [9:0] exp_x [8];
        logic [2:0] exp_s [8];
        exp_x = '{10'd101, 10'd102, 10'd104, 10'd106, 10'd109, 10'd112, 10'd116, 10'd120};
        exp_s = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4};
        apply_reset();
        btn_right = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            do_tick();
            checks++;
            if (car_x !== exp_x[i] || speed !== exp_s[i]) begin
                errors++;
                $display("FAIL accel_tick%0d: car_x=%0d speed=%0d expected %0d %0d",
                         i, car_x, speed, exp_x[i], exp_s[i]);
            end
        end
        btn_right = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_edges();
        logic [9:0] exp_hi [3];
        exp_hi = '{10'd599, 10'd600, 10'd600};
        apply_reset();
        checks++;
        if (hi_x !== 10'd598 || lo_x !== 10'd1) begin
            errors++;
            $display("FAIL edge_init: hi_x=%0d lo_x=%0d expected 598 1", hi_x, lo_x);
        end
        hi_right = 1'b1;
        lo_left  = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            checks++;
            if (hi_x !== exp_hi[i]) begin
                errors++;
                $display("FAIL right_clamp tick%0d: car_x=%0d expected %0d", i, hi_x, exp_hi[i]);
            end
            checks++;
            if (lo_x !== 10'd0) begin
                errors++;
                $display("FAIL left_clamp tick%0d: car_x=%0d expected 0", i, lo_x);
            end
        end
        checks++;
        if (hi_speed !== 3'd2 || lo_speed !== 3'd2) begin
            errors++;
            $display("FAIL clamp_keeps_speed: hi=%0d lo=%0d expected 2 2", hi_speed, lo_speed);
        end
        hi_right = 1'b0;
        lo_left  = 1'b0;
    endtask

    task automatic test_both_buttons();
        apply_reset();
        btn_right = 1'b1;
        repeat (8) @(negedge clk);
        repeat (4) do_tick();
        checks++;
        if (car_x !== 10'd106 || speed !== 3'd3) begin
            errors++;
            $display("FAIL pre_both: car_x=%0d speed=%0d expected 106 3", car_x, speed);
        end
        btn_left = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (moving !== 1'b0 || speed !== 3'd1 || car_x !== 10'd106) begin
            errors++;
            $display("FAIL both_idle: moving=%0d speed=%0d car_x=%0d expected 0 1 106",
                     moving, speed, car_x);
        end
        repeat (2) do_tick();
        checks++;
        if (car_x !== 10'd106) begin
            errors++;
            $display("FAIL both_frozen: car_x=%0d expected 106", car_x);
        end
        btn_right = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (moving !== 1'b1 || dir_left !== 1'b1 || speed !== 3'd1) begin
            errors++;
            $display("FAIL left_after_release: moving=%0d dir_left=%0d speed=%0d expected 1 1 1",
                     moving, dir_left, speed);
        end
        do_tick();
        checks++;
        if (car_x !== 10'd105) begin
            errors++;
            $display("FAIL left_after_release_tick: car_x=%0d expected 105", car_x);
        end
        btn_left = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        btn_right = 1'b1;
        repeat (8) @(negedge clk);
        repeat (6) do_tick();
        checks++;
        if (speed !== 3'd4 || car_x !== 10'd112) begin
            errors++;
            $display("FAIL pre_async: speed=%0d car_x=%0d expected 4 112", speed, car_x);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (car_x !== 10'd100 || speed !== 3'd1 || moving !== 1'b0 || dir_left !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: car_x=%0d speed=%0d moving=%0d dir_left=%0d expected 100 1 0 0",
                     car_x, speed, moving, dir_left);
        end
        btn_right = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce_latency();
        test_accel();
        test_edges();
        test_both_buttons();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
